regfile_fwd: RTL
================

Name: regfile_fwd

Overview:
- General-purpose register file for the 5-stage MIPS pipeline. It sinks the write-back result (wreg/wd/wdata) carried down from the EX stage through MEM/WB.
- It sources the two operands that feed id_ex and then EX.
- Integrates forwarding from the live EX and MEM stage outputs, so back-to-back dependent ALU ops need no bubbles.
- Raises a stall request on a load-use hazard.

Parameters:
- DATA_W, 32, register/data width (`RegBus).
- ADDR_W, 5, register address width (`RegAddrBus).
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- we  in  1  write-back enable from mem_wb
- waddr  in  ADDR_W  write-back register address
- wdata  in  DATA_W  write-back data
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data
- ex_wreg  in  1  EX stage write-enable output (ex_wreg_o)
- ex_wd  in  ADDR_W  EX stage destination (ex_wd_o)
- ex_wdata  in  DATA_W  EX stage result (ex_wdata_o)
- ex_is_load  in  1  instruction in EX is a load; its result is not yet valid
- mem_wreg  in  1  MEM stage write-enable
- mem_wd  in  ADDR_W  MEM stage destination
- mem_wdata  in  DATA_W  MEM stage result
- stallreq  out  1  load-use hazard; ctrl freezes PC/if_id/id_ex for one cycle

Behaviour:
- Storage: NUM_REGS x DATA_W array.
  - Written on rising clk when we=1, rst=0 and waddr!=0.
  - Register 0 is never written and always reads 0.
- Reset: rst=1 at a clk edge clears every array entry to `ZeroWord. While rst=1, rdata1=rdata2=0 and stallreq=0 combinationally.
- Reads are combinational, zero latency. Per port, priority is highest first:
  1. rst=1 -> 0.
  2. re=0 -> 0.
  3. raddr=0 -> 0. Forwarding never applies to $0, even if ex_wd=0 with ex_wreg=1.
  4. ex_wreg=1 and ex_wd==raddr -> ex_wdata. The youngest producer wins.
  5. mem_wreg=1 and mem_wd==raddr -> mem_wdata.
  6. we=1 and waddr==raddr -> wdata. This is the same-cycle write-through bypass.
  7. Otherwise -> the array entry.
- Both ports are independent. raddr1==raddr2 returns identical data.
- Load-use hazard:
  - stallreq=1 when ex_is_load=1, ex_wreg=1, ex_wd!=0, and (re1=1 and raddr1==ex_wd) or (re2=1 and raddr2==ex_wd).
  - Combinational, asserted only in the cycle the hazard exists.
  - While stallreq=1, rdata still follows the priority list (it shows ex_wdata); the id_ex bubble makes that value unused.
  - On the next cycle the load sits in MEM, and the MEM forward path supplies its data.
- Simultaneous events:
  - A WB write and a read of the same address in one cycle returns the new wdata. The array updates at the edge.
  - EX, MEM and WB all targeting the same address: EX wins.
  - rst=1 together with we=1: the reset clear wins and nothing is written.
- Reset mid-operation: array contents are lost. Pending forwarding inputs are ignored while rst=1.
- Widths: all compares are full ADDR_W equality. No arithmetic.

Decomposition:
- Shared defines (defines.v): `RegBus, `RegAddrBus, `RegNum, `RegNumLog2, `NOPRegAddr, `ZeroWord, `RstEnable, `WriteEnable, `ReadEnable, `Stop.
- One sub-module: fwd_mux, instantiated once per read port. It is a combinational priority selector taking the port's re/raddr, the three forward sources and the array word.
- The stall comparator and the array stay in regfile_fwd.

Test Plan:
- Reset and $0:
  - Stimulus: pulse rst one cycle, then read all 32 registers; then write we=1, waddr=0, wdata=32'hDEADBEEF.
  - Required: every read returns 0, and a later read of $0 returns 0.
- WB write-through and storage:
  - Stimulus: we=1, waddr=5, wdata=32'h1234_5678, re1=1, raddr1=5 in the same cycle.
  - Required: rdata1=32'h12345678 in that cycle and after the edge with we=0.
- Forward priority:
  - Stimulus: array r7=1; mem_wreg=1, mem_wd=7, mem_wdata=2; ex_wreg=1, ex_wd=7, ex_wdata=3; we=1, waddr=7, wdata=4.
  - Required: rdata2=3. Drop ex_wreg and rdata2=2. Drop mem_wreg and rdata2=4.
- Read enable gating:
  - Stimulus: r9=32'hAA, re1=0, raddr1=9, ex_wreg=1, ex_wd=9.
  - Required: rdata1=0.
- Load-use:
  - Stimulus: ex_is_load=1, ex_wreg=1, ex_wd=3, re2=1, raddr2=3.
  - Required: stallreq=1. Next cycle, with mem_wd=3, mem_wreg=1, mem_wdata=32'h55 and ex_is_load=0, stallreq=0 and rdata2=32'h55.
- Reset mid-operation:
  - Stimulus: write r4=32'hF0, then assert rst with we=1, waddr=4, wdata=32'h0F.
  - Required: after rst deasserts, reading r4 returns 0.

Source files
------------

// File: rtl/regfile_fwd_pkg.sv
// Shared widths and the read-port source encoding for the forwarding register file.
package regfile_fwd_pkg;

  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned REG_NUM      = 2 ** REG_ADDR_BUS;

  // Which source drives a read port this cycle.
  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_EX,
    SRC_MEM,
    SRC_WB,
    SRC_ARRAY
  } fwd_src_e;

endpackage

// File: rtl/regfile_fwd_fwd_mux.sv
// Per-port priority selector: reset/disable/$0, then EX, MEM, WB bypass, then array.
module fwd_mux
  import regfile_fwd_pkg::*;
#(
  parameter int unsigned DATA_W = REG_BUS,
  parameter int unsigned ADDR_W = REG_ADDR_BUS
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] array_word,
  output logic [DATA_W-1:0] rdata
);

  fwd_src_e src;

  always_comb begin
    src = SRC_ARRAY;
    if (rst || !re || raddr == '0)         src = SRC_ZERO;
    else if (ex_wreg && ex_wd == raddr)    src = SRC_EX;
    else if (mem_wreg && mem_wd == raddr)  src = SRC_MEM;
    else if (we && waddr == raddr)         src = SRC_WB;
  end

  always_comb begin
    rdata = '0;
    unique case (src)
      SRC_ZERO:  rdata = '0;
      SRC_EX:    rdata = ex_wdata;
      SRC_MEM:   rdata = mem_wdata;
      SRC_WB:    rdata = wdata;
      SRC_ARRAY: rdata = array_word;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/regfile_fwd.sv
// MIPS GPR file with EX/MEM/WB forwarding on both read ports and load-use stall detection.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_BUS,
  parameter int unsigned ADDR_W   = REG_ADDR_BUS,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              stallreq
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .rst(rst), .re(re1), .raddr(raddr1),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .array_word(regs[raddr1]), .rdata(rdata1)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .rst(rst), .re(re2), .raddr(raddr2),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .array_word(regs[raddr2]), .rdata(rdata2)
  );

  // A load in EX has no data yet; any dependent read must wait one cycle for MEM forwarding.
  always_comb begin
    stallreq = 1'b0;
    if (!rst && ex_is_load && ex_wreg && ex_wd != '0)
      stallreq = (re1 && raddr1 == ex_wd) || (re2 && raddr2 == ex_wd);
  end

endmodule
